// File: rtl/cp0_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl_pkg
// Shared constants for the coprocessor-0 interrupt responder:
//   - CP0 register numbers, as they appear in the mfc0/mtc0 rd field
//   - bit positions of the SR/Cause fields that are implemented
// ---------------------------------------------------------------------------
package cp0_irq_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned IM_HI   = 15;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned IE_BIT  = 0;

endpackage

// File: rtl/cp0_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl
// Coprocessor-0 interrupt responder. Holds SR (IM/EXL/IE), Cause (IP),
// EPC and a constant PRId. It serves mfc0 reads and mtc0 writes, samples
// the peripheral IRQ levels into Cause.IP, and raises IRQ_O to the pipeline.
//
// Ports:
//   CLK_I      clock
//   RST_I      asynchronous, active-high reset
//   SEL_I      CP0 register number (rd field) for mfc0/mtc0
//   WE_I       mtc0 write strobe
//   DAT_I      mtc0 write data
//   DAT_O      mfc0 read data, combinational from SEL_I
//   PC_I       victim PC, captured into EPC on exception entry
//   EXL_SET_I  exception/interrupt entry strobe
//   EXL_CLR_I  eret strobe
//   HWINT_I    peripheral IRQ levels -> Cause.IP[15:10]
//   IRQ_O      interrupt request to the pipeline
//   EPC_O      current EPC, feeds the eret target mux
// ---------------------------------------------------------------------------
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_4D50
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [4:0]  SEL_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic [31:0] PC_I,
    input  logic        EXL_SET_I,
    input  logic        EXL_CLR_I,
    input  logic [5:0]  HWINT_I,
    output logic        IRQ_O,
    output logic [31:0] EPC_O
);

    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic [5:0]  ip_q;
    logic [31:0] epc_q, epc_d;

    logic [31:0] sr_img;
    logic [31:0] cause_img;

    // Later assignments win: mtc0 first, then eret, then exception entry,
    // so entry overrides both an eret and a concurrent EPC/EXL write.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        epc_d = epc_q;

        if (WE_I && (SEL_I == CP0_SR)) begin
            im_d  = DAT_I[IM_HI:IM_LO];
            exl_d = DAT_I[EXL_BIT];
            ie_d  = DAT_I[IE_BIT];
        end
        if (WE_I && (SEL_I == CP0_EPC)) begin
            epc_d = {DAT_I[31:2], 2'b00};
        end
        if (EXL_CLR_I) begin
            exl_d = 1'b0;
        end
        if (EXL_SET_I) begin
            exl_d = 1'b1;
            epc_d = {PC_I[31:2], 2'b00};
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= HWINT_I;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_img                 = '0;
        sr_img[IM_HI:IM_LO]    = im_q;
        sr_img[EXL_BIT]        = exl_q;
        sr_img[IE_BIT]         = ie_q;
        cause_img              = '0;
        cause_img[IM_HI:IM_LO] = ip_q;
    end

    always_comb begin
        DAT_O = '0;
        case (SEL_I)
            CP0_SR:    DAT_O = sr_img;
            CP0_CAUSE: DAT_O = cause_img;
            CP0_EPC:   DAT_O = epc_q;
            CP0_PRID:  DAT_O = PRID_VAL;
            default:   DAT_O = '0;
        endcase
    end

    // Built only from register outputs, so reset drops it without a clock.
    assign IRQ_O = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign EPC_O = epc_q;

endmodule
